// File: rtl/vx_commit_arb_if.sv
// Commit-stream bundle between the execute units (in_*) and the writeback port (out_*).
// master drives the source side and consumes the merged stream; slave is the arbiter.

interface vx_commit_arb_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_W     = 128,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0]             in_valid;
    logic [NUM_INPUTS-1:0][DATA_W-1:0] in_data;
    logic [NUM_INPUTS-1:0]             in_sop;
    logic [NUM_INPUTS-1:0]             in_eop;
    logic [NUM_INPUTS-1:0]             in_ready;

    logic                              out_valid;
    logic [DATA_W-1:0]                 out_data;
    logic                              out_sop;
    logic                              out_eop;
    logic [SEL_W-1:0]                  out_sel;
    logic                              out_ready;

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_sel
    );
endinterface

// File: rtl/vx_commit_arb.sv
// Round-robin merge of per-unit commit streams onto one writeback port.
// Multi-beat packets keep the grant until eop; output is decoupled by a 2-entry FIFO.

module vx_commit_arb_lane #(
    parameter int IDX   = 0,
    parameter int SEL_W = 2
) (
    input  logic             reset,
    input  logic             valid,
    input  logic             hi,
    input  logic             grant_vld,
    input  logic [SEL_W-1:0] grant_idx,
    input  logic             space,
    output logic             req_hi,
    output logic             ready
);
    localparam logic [SEL_W-1:0] ID = SEL_W'(IDX);

    assign req_hi = valid && hi;
    assign ready  = !reset && space && grant_vld && (grant_idx == ID);
endmodule

module vx_commit_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_W     = 128,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic           clk,
    input  logic           reset,
    vx_commit_arb_if.slave bus,
    output logic [31:0]    stall_cycles
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [SEL_W-1:0]  sel;
    } ent_t;

    typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INPUTS - 1);

    arb_state_e            state;
    logic [SEL_W-1:0]      rr_ptr;
    logic [SEL_W-1:0]      lock_src;

    ent_t                  fifo_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  space;
    logic                  push;
    logic                  pop;
    ent_t                  push_ent;
    ent_t                  head;

    logic [NUM_INPUTS-1:0] hi_mask;
    logic [NUM_INPUTS-1:0] req_hi;
    logic [NUM_INPUTS-1:0] ready;
    logic                  grant_vld;
    logic [SEL_W-1:0]      grant_idx;

    assign space = (count != 2'd2);
    assign pop   = (count != 2'd0) && bus.out_ready;

    // Sources at or above rr_ptr get first pick; the rest only if none of those are valid.
    assign hi_mask = ~((NUM_INPUTS'(1) << rr_ptr) - NUM_INPUTS'(1));

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == ARB_LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = lock_src;
        end else if (|req_hi) begin
            grant_vld = 1'b1;
            for (int i = NUM_INPUTS - 1; i >= 0; i--)
                if (req_hi[i]) grant_idx = SEL_W'(i);
        end else if (|bus.in_valid) begin
            grant_vld = 1'b1;
            for (int i = NUM_INPUTS - 1; i >= 0; i--)
                if (bus.in_valid[i]) grant_idx = SEL_W'(i);
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        vx_commit_arb_lane #(
            .IDX   (i),
            .SEL_W (SEL_W)
        ) u_lane (
            .reset     (reset),
            .valid     (bus.in_valid[i]),
            .hi        (hi_mask[i]),
            .grant_vld (grant_vld),
            .grant_idx (grant_idx),
            .space     (space),
            .req_hi    (req_hi[i]),
            .ready     (ready[i])
        );
    end

    assign bus.in_ready = ready;
    assign push         = |(bus.in_valid & ready);

    always_comb begin
        push_ent      = '0;
        push_ent.data = bus.in_data[grant_idx];
        push_ent.sop  = bus.in_sop[grant_idx];
        push_ent.eop  = bus.in_eop[grant_idx];
        push_ent.sel  = grant_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= push_ent;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_OPEN;
            rr_ptr   <= '0;
            lock_src <= '0;
        end else if (push) begin
            if (push_ent.eop) begin
                state  <= ARB_OPEN;
                rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + SEL_W'(1);
            end else begin
                state    <= ARB_LOCKED;
                lock_src <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (bus.out_valid && !bus.out_ready && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end

    assign head          = fifo_q[rd_ptr];
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head.data;
    assign bus.out_sop   = head.sop;
    assign bus.out_eop   = head.eop;
    assign bus.out_sel   = head.sel;

    // A continuation beat arriving while unlocked is still accepted; only flag it.
    a_sop_when_open: assert property (@(posedge clk) disable iff (reset)
        (push && state == ARB_OPEN) |-> push_ent.sop);
endmodule

// File: tb/tb_vx_commit_arb.sv
// Bench for vx_commit_arb: directed scenarios plus random packet traffic,
// checked every cycle against a queue-based model of arbitration and buffering.

module tb_vx_commit_arb;
    localparam int N  = 4;
    localparam int DW = 128;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] data;
        bit            sop;
        bit            eop;
        int            gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            sop;
        bit            eop;
        int            sel;
    } obeat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stall_cycles;

    vx_commit_arb_if #(.NUM_INPUTS(N), .DATA_W(DW)) bus ();

    vx_commit_arb #(.NUM_INPUTS(N), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    beat_t       srcq [N][$];
    obeat_t      expq [$];
    int          m_rr;
    bit          m_locked;
    int          m_lock;
    logic [31:0] m_stall;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_locked = 0;
        m_lock = 0;
        m_stall = '0;
        expq.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic add_pkt(input int s, input int len, input int maxgap);
        for (int b = 0; b < len; b++) begin
            beat_t t;
            t.data = rnd_data();
            t.sop  = (b == 0);
            t.eop  = (b == len - 1);
            t.gap  = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            srcq[s].push_back(t);
        end
    endtask

    // One clock: drive sources, check DUT against model, then advance the model at the edge.
    task automatic step(input bit ordy);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        int           g;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && srcq[i][0].gap == 0) begin
                v[i] = 1'b1;
                bus.in_data[i] = srcq[i][0].data;
                bus.in_sop[i]  = srcq[i][0].sop;
                bus.in_eop[i]  = srcq[i][0].eop;
            end else begin
                bus.in_data[i] = '0;
                bus.in_sop[i]  = 1'b0;
                bus.in_eop[i]  = 1'b0;
            end
        end
        bus.in_valid  = v;
        bus.out_ready = ordy;

        exp_rdy = '0;
        g = -1;
        if (!reset && expq.size() < 2) begin
            if (m_locked) g = m_lock;
            else
                for (int k = 0; k < N; k++)
                    if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) exp_rdy[g] = 1'b1;
        end

        #1;
        chk("in_ready", 160'(bus.in_ready), 160'(exp_rdy));
        chk("out_valid", 160'(bus.out_valid), 160'(expq.size() > 0));
        if (expq.size() > 0)
            chk("out_beat", 160'({bus.out_data, bus.out_sop, bus.out_eop, bus.out_sel}),
                160'({expq[0].data, expq[0].sop, expq[0].eop, SW'(expq[0].sel)}));
        chk("stall_cycles", 160'(stall_cycles), 160'(m_stall));

        @(posedge clk);
        if (!reset) begin
            if (expq.size() > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (expq.size() > 0 && ordy) void'(expq.pop_front());
            if (g >= 0 && v[g]) begin
                beat_t  b;
                obeat_t o;
                b = srcq[g].pop_front();
                o.data = b.data;
                o.sop  = b.sop;
                o.eop  = b.eop;
                o.sel  = g;
                expq.push_back(o);
                if (b.eop) begin
                    m_locked = 0;
                    m_rr = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_lock = g;
                end
            end
            for (int i = 0; i < N; i++)
                if (!v[i] && srcq[i].size() > 0) begin
                    beat_t t;
                    t = srcq[i][0];
                    if (t.gap > 0) t.gap--;
                    srcq[i][0] = t;
                end
        end
        #1;
    endtask

    initial begin
        beat_t t;
        reset = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_sop    = '0;
        bus.in_eop    = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #2;
        chk("reset_out", 160'({bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_sel}), 160'(0));
        step(1);
        step(1);
        reset = 1'b0;
        step(1);

        // Single-beat packet on source 2, then sources 0 and 3 together: rr_ptr=3 picks 3.
        t.data = 128'hA5; t.sop = 1; t.eop = 1; t.gap = 0;
        srcq[2].push_back(t);
        repeat (3) step(1);
        add_pkt(0, 1, 0);
        add_pkt(3, 1, 0);
        repeat (4) step(1);

        // Fairness: all four sources continuously offering single beats.
        for (int s = 0; s < N; s++) repeat (3) add_pkt(s, 1, 0);
        repeat (16) step(1);

        // Atomicity: source 1 three-beat packet with a gap before beat 2, source 0 always valid.
        repeat (5) add_pkt(0, 1, 0);
        t.data = rnd_data(); t.sop = 1; t.eop = 0; t.gap = 0; srcq[1].push_back(t);
        t.data = rnd_data(); t.sop = 0; t.eop = 0; t.gap = 1; srcq[1].push_back(t);
        t.data = rnd_data(); t.sop = 0; t.eop = 1; t.gap = 0; srcq[1].push_back(t);
        add_pkt(2, 1, 0);
        repeat (14) step(1);

        // Backpressure: source 3 streams while out_ready is low, then drains.
        repeat (4) add_pkt(3, 1, 0);
        repeat (5) step(0);
        repeat (8) step(1);

        // Reset after beat 1 of a two-beat packet from source 0.
        add_pkt(0, 2, 0);
        step(1);
        reset = 1'b1;
        model_reset();
        step(1);
        reset = 1'b0;
        add_pkt(1, 1, 0);
        repeat (3) step(1);

        // Stall counter saturation.
        add_pkt(2, 1, 0);
        step(1);
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        m_stall = 32'hFFFF_FFFE;
        repeat (4) step(0);
        repeat (2) step(1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < N; s++)
                if (srcq[s].size() == 0 && $urandom_range(0, 3) == 0)
                    add_pkt(s, int'($urandom_range(1, 3)), 2);
            step($urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 80; c++) step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
